spi_ram_arbiter: RTL and testbench
==================================

Name: spi_ram_arbiter

Overview:
- Sits between the SPI slave's 10-bit command stream and a single-port RAM.
- Decodes SPI commands, keeps separate write and read address registers, and shares the RAM with a local host port using round-robin arbitration.
- Returns SPI read data to the SPI slave's serializer as an 8-bit word with a one-cycle valid pulse.

Parameters:
- MEM_DEPTH, 256, number of RAM words.
- ADDR_SIZE, 8, RAM address width (log2 of MEM_DEPTH).
- DATA_W, 8, RAM word width; must equal rx_data payload width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- rx_data  in  10  SPI word: [9:8] command, [7:0] payload.
- rx_valid  in  1  one-cycle strobe qualifying rx_data.
- tx_data  out  8  SPI read data back to the slave serializer.
- tx_valid  out  1  one-cycle strobe qualifying tx_data.
- host_req  in  1  host access request; level, held until host_gnt.
- host_we  in  1  1 = write, 0 = read; stable while host_req is high.
- host_addr  in  ADDR_SIZE  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  one-cycle pulse in the cycle the host access is issued to RAM.
- host_rvalid  out  1  one-cycle pulse qualifying host_rdata.
- host_rdata  out  DATA_W  host read data.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_SIZE  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after an mem_en read.
- spi_ovf  out  1  sticky flag: an SPI memory command was dropped.

Behaviour:
- Reset: tx_data=0, tx_valid=0, host_gnt=0, host_rvalid=0, host_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, spi_ovf=0.
- Reset also clears wr_addr, rd_addr, the pending entry and last_grant (0 = SPI wins the next tie), and forces state IDLE. Reset mid-access aborts the access; no valid pulse follows.
- SPI command decode, on rx_valid:
  - 00: wr_addr <= payload.
  - 10: rd_addr <= payload.
  - Both take effect the next edge regardless of FSM state and never set pending.
  - 01 (write data): set the pending entry {we=1, addr=wr_addr, data=payload}.
  - 11 (read data): set the pending entry {we=0, addr=rd_addr}. The address is captured at acceptance, so a later 10 command does not alter it.
- Pending entry is one deep. A 01/11 command arriving while pending is set and not being granted that cycle is dropped and sets spi_ovf, which holds until rst. Arrival in the same cycle the pending entry is granted is accepted without overflow.
- FSM states: IDLE, SPI_ACC, HOST_ACC, SPI_RSP, HOST_RSP.
  - IDLE: if only pending is set, go to SPI_ACC. If only host_req is set, go to HOST_ACC. If both, grant the side not granted last (last_grant), then update last_grant.
  - SPI_ACC (1 cycle): mem_en=1, mem_we/addr/wdata from the pending entry; pending clears at the edge. Write goes to IDLE; read goes to SPI_RSP.
  - HOST_ACC (1 cycle): mem_en=1, mem_* from host fields, host_gnt=1. Write goes to IDLE; read goes to HOST_RSP.
  - SPI_RSP: tx_data <= mem_rdata, tx_valid pulses the following cycle; go to IDLE. tx_data holds until the next SPI read.
  - HOST_RSP: host_rdata <= mem_rdata, host_rvalid pulses the following cycle; go to IDLE.
- mem_en and mem_we are 0 outside the ACC states. mem_addr/mem_wdata hold their last value.
- Latency, with rx_valid in cycle N:
  - 11 command: mem_en in N+2, tx_valid in N+4.
  - 01 command: write in N+2.
  - Host with request first seen in IDLE at cycle M: gnt in M+1; read gives host_rvalid in M+3.
- Back-to-back: an idle-to-idle access costs 2 cycles for a write and 3 for a read. Sustained contention alternates SPI and host.
- Address wrap: addresses are ADDR_SIZE bits. Payload bits above ADDR_SIZE are ignored when ADDR_SIZE < 8. There is no auto-increment.

Decomposition:
- Shared package spi_ram_pkg:
  - Command codes CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - FSM state encoding (one-hot, 5 bits).
  - Pending-entry field widths.
- One sub-module: rr_arbiter2, a two-requester round-robin arbiter with a last_grant register, updated only on an accepted grant.

Test Plan:
- rx 0x005 (wr_addr=5), rx 0x1A5 (write A5) -> mem_en=1, mem_we=1, mem_addr=5, mem_wdata=A5 two cycles after the second strobe; tx_valid stays 0.
- rx 0x205, rx 0x300 with mem_rdata=A5 -> mem read at addr 5, tx_valid one cycle at N+4, tx_data=A5.
- host_req read addr 0x10 with mem_rdata=3C, no SPI traffic -> host_gnt one cycle later, host_rvalid two cycles after gnt, host_rdata=3C.
- SPI write pending plus host_req asserted in the same IDLE cycle after reset -> SPI granted first, host next. Repeat the tie -> grants alternate S, H, S, H.
- Two 01 commands while the host holds the RAM -> first executes, second dropped, spi_ovf=1 until rst.
- rst asserted during SPI_RSP -> tx_valid never pulses, all outputs 0 next cycle, pending cleared, the next 11 command uses rd_addr=0.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-to-RAM arbiter: command codes, FSM state
// encoding and pending-entry field widths.
package spi_ram_pkg;

    localparam int RX_W      = 10;
    localparam int CMD_W     = 2;
    localparam int PAYLOAD_W = 8;

    localparam logic [CMD_W-1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [CMD_W-1:0] CMD_WR_DATA = 2'b01;
    localparam logic [CMD_W-1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [CMD_W-1:0] CMD_RD_DATA = 2'b11;

    // Pending entry fields: {valid, we, addr, data}; addr/data widths follow
    // the ADDR_SIZE / DATA_W parameters of the top module.
    localparam int PEND_VALID_W = 1;
    localparam int PEND_WE_W    = 1;

    typedef enum logic [4:0] {
        ST_IDLE     = 5'b00001,
        ST_SPI_ACC  = 5'b00010,
        ST_HOST_ACC = 5'b00100,
        ST_SPI_RSP  = 5'b01000,
        ST_HOST_RSP = 5'b10000
    } state_t;

    // Commands 01 and 11 carry a memory access; 00 and 10 only load addresses.
    function automatic logic is_mem_cmd(input logic [CMD_W-1:0] cmd);
        return cmd[0];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. last_grant = 1 means requester A won
// the previous accepted grant, so B wins the next tie.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic accept,
    output logic gnt_a,
    output logic gnt_b
);

    logic last_grant;

    // Grant decision: a lone requester wins, a tie goes to the side not served last.
    always_comb begin
        gnt_a = accept && req_a && (!req_b || !last_grant);
        gnt_b = accept && req_b && (!req_a ||  last_grant);
    end

    // Remember who was served, only when a grant is actually taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b0;
        end else if (gnt_a) begin
            last_grant <= 1'b1;
        end else if (gnt_b) begin
            last_grant <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// SPI command decoder and RAM sharing between the SPI slave and a local host.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting; arbitrate between pending SPI entry and host_req
// SPI_ACC   | RAM access from the pending SPI entry (pending clears)
// HOST_ACC  | RAM access from the host fields, host_gnt pulses
// SPI_RSP   | capture mem_rdata into tx_data, tx_valid next cycle
// HOST_RSP  | capture mem_rdata into host_rdata, host_rvalid next cycle
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int DATA_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [RX_W-1:0]      rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [DATA_W-1:0]    host_wdata,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [DATA_W-1:0]    host_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 spi_ovf
);

    if (DATA_W != PAYLOAD_W || ADDR_SIZE > PAYLOAD_W || MEM_DEPTH != (1 << ADDR_SIZE)) begin : g_param_check
        $error("spi_ram_arbiter: inconsistent MEM_DEPTH/ADDR_SIZE/DATA_W");
    end

    logic [CMD_W-1:0]     cmd;
    logic [PAYLOAD_W-1:0] payload;
    logic                 mem_cmd;
    logic                 pend_free;

    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 pend_valid;
    logic                 pend_we;
    logic [ADDR_SIZE-1:0] pend_addr;
    logic [DATA_W-1:0]    pend_data;

    logic                 gnt_spi;
    logic                 gnt_host;
    state_t               state;

    // Split the SPI word; the pending slot frees up in the cycle it is consumed.
    always_comb begin
        cmd       = rx_data[RX_W-1 -: CMD_W];
        payload   = rx_data[PAYLOAD_W-1:0];
        mem_cmd   = rx_valid && is_mem_cmd(cmd);
        pend_free = !pend_valid || (state == ST_SPI_ACC);
    end

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_a  (pend_valid),
        .req_b  (host_req),
        .accept (state == ST_IDLE),
        .gnt_a  (gnt_spi),
        .gnt_b  (gnt_host)
    );

    // Command decode: address registers, one-deep pending entry, sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr    <= '0;
            rd_addr    <= '0;
            pend_valid <= 1'b0;
            pend_we    <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            spi_ovf    <= 1'b0;
        end else begin
            if (rx_valid && cmd == CMD_WR_ADDR) begin
                wr_addr <= payload[ADDR_SIZE-1:0];
            end
            if (rx_valid && cmd == CMD_RD_ADDR) begin
                rd_addr <= payload[ADDR_SIZE-1:0];
            end
            if (state == ST_SPI_ACC) begin
                pend_valid <= 1'b0;
            end
            if (mem_cmd) begin
                if (pend_free) begin
                    pend_valid <= 1'b1;
                    pend_we    <= (cmd == CMD_WR_DATA);
                    pend_addr  <= (cmd == CMD_WR_DATA) ? wr_addr : rd_addr;
                    pend_data  <= payload[DATA_W-1:0];
                end else begin
                    spi_ovf <= 1'b1;
                end
            end
        end
    end

    // Access sequencer with registered RAM, grant and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            host_gnt    <= 1'b0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            host_gnt    <= 1'b0;
            tx_valid    <= 1'b0;
            host_rvalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_spi) begin
                        state     <= ST_SPI_ACC;
                        mem_en    <= 1'b1;
                        mem_we    <= pend_we;
                        mem_addr  <= pend_addr;
                        mem_wdata <= pend_data;
                    end else if (gnt_host) begin
                        state     <= ST_HOST_ACC;
                        mem_en    <= 1'b1;
                        mem_we    <= host_we;
                        mem_addr  <= host_addr;
                        mem_wdata <= host_wdata;
                        host_gnt  <= 1'b1;
                    end
                end
                ST_SPI_ACC: begin
                    state <= mem_we ? ST_IDLE : ST_SPI_RSP;
                end
                ST_HOST_ACC: begin
                    state <= mem_we ? ST_IDLE : ST_HOST_RSP;
                end
                ST_SPI_RSP: begin
                    tx_data  <= mem_rdata;
                    tx_valid <= 1'b1;
                    state    <= ST_IDLE;
                end
                ST_HOST_RSP: begin
                    host_rdata  <= mem_rdata;
                    host_rvalid <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a behavioural single-port RAM.
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       host_req;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt;
    logic       host_rvalid;
    logic [7:0] host_rdata;
    logic       mem_en;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       spi_ovf;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    spi_ram_arbiter #(.MEM_DEPTH(256), .ADDR_SIZE(8), .DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .spi_ovf     (spi_ovf)
    );

    logic [7:0] ram [256];
    initial mem_rdata = 8'h00;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_addr;
        logic [7:0] exp_tx;
    } vec_t;

    vec_t vecs [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    task automatic send_rx(input logic [9:0] w);
        rx_data  = w;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [1:0] g_who  [4];
    logic [7:0] g_addr [4];
    int         n_gnt;
    int         cnt;

    initial begin
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

        vecs[0] = '{8'h05, 8'hA5, 8'h05, 8'hA5};
        vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{8'hFF, 8'h5A, 8'hFF, 8'h5A};
        vecs[3] = '{8'h80, 8'hFF, 8'h80, 8'hFF};
        vecs[4] = '{8'h33, 8'hC3, 8'h33, 8'hC3};

        step(); step();
        chk8("rst_tx_data", tx_data, 8'h00);
        chk1("rst_tx_valid", tx_valid, 1'b0);
        chk1("rst_host_gnt", host_gnt, 1'b0);
        chk1("rst_host_rvalid", host_rvalid, 1'b0);
        chk8("rst_host_rdata", host_rdata, 8'h00);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk8("rst_mem_addr", mem_addr, 8'h00);
        chk8("rst_mem_wdata", mem_wdata, 8'h00);
        chk1("rst_spi_ovf", spi_ovf, 1'b0);
        rst = 1'b0;
        step();

        // SPI write then read-back per vector; latencies N+2 and N+4.
        for (int i = 0; i < 5; i++) begin
            send_rx({2'b00, vecs[i].addr});
            send_rx({2'b01, vecs[i].data});
            step();
            chk1("wr_mem_en", mem_en, 1'b1);
            chk1("wr_mem_we", mem_we, 1'b1);
            chk8("wr_mem_addr", mem_addr, vecs[i].exp_addr);
            chk8("wr_mem_wdata", mem_wdata, vecs[i].data);
            chk1("wr_no_tx", tx_valid, 1'b0);
            step();
            send_rx({2'b10, vecs[i].addr});
            send_rx({2'b11, 8'h00});
            step();
            chk1("rd_mem_en", mem_en, 1'b1);
            chk1("rd_mem_we", mem_we, 1'b0);
            chk8("rd_mem_addr", mem_addr, vecs[i].exp_addr);
            step();
            chk1("rd_tx_early", tx_valid, 1'b0);
            step();
            chk1("rd_tx_valid", tx_valid, 1'b1);
            chk8("rd_tx_data", tx_data, vecs[i].exp_tx);
            step();
            chk1("rd_tx_pulse", tx_valid, 1'b0);
            chk8("rd_tx_hold", tx_data, vecs[i].exp_tx);
        end

        // Host write 0x10=3C, then host read of 0x10.
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h3C;
        step();
        chk1("hw_gnt", host_gnt, 1'b1);
        chk1("hw_mem_we", mem_we, 1'b1);
        chk8("hw_mem_addr", mem_addr, 8'h10);
        chk8("hw_mem_wdata", mem_wdata, 8'h3C);
        host_req = 1'b0;
        step();
        chk1("hw_gnt_pulse", host_gnt, 1'b0);
        host_req = 1'b1; host_we = 1'b0; host_wdata = 8'h00;
        step();
        chk1("hr_gnt", host_gnt, 1'b1);
        chk1("hr_mem_en", mem_en, 1'b1);
        chk1("hr_mem_we", mem_we, 1'b0);
        host_req = 1'b0;
        step();
        chk1("hr_gnt_pulse", host_gnt, 1'b0);
        chk1("hr_rvalid_early", host_rvalid, 1'b0);
        step();
        chk1("hr_rvalid", host_rvalid, 1'b1);
        chk8("hr_rdata", host_rdata, 8'h3C);
        chk1("hr_no_tx", tx_valid, 1'b0);
        step();
        chk1("hr_rvalid_pulse", host_rvalid, 1'b0);

        // Sustained contention after reset: SPI first, then alternate.
        apply_reset();
        send_rx({2'b01, 8'h77});
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'h11;
        n_gnt = 0;
        for (int c = 0; c < 16; c++) begin
            step();
            rx_valid = 1'b0;
            if (mem_en && n_gnt < 4) begin
                g_who[n_gnt]  = host_gnt ? 2'd2 : 2'd1;
                g_addr[n_gnt] = mem_addr;
                n_gnt++;
                if (!host_gnt && n_gnt < 4) begin
                    rx_data  = {2'b01, 8'h40 | 8'(n_gnt)};
                    rx_valid = 1'b1;
                end
                if (n_gnt == 4) host_req = 1'b0;
            end
        end
        rx_valid = 1'b0;
        chk8("rr_grant0", {6'd0, g_who[0]}, 8'd1);
        chk8("rr_grant1", {6'd0, g_who[1]}, 8'd2);
        chk8("rr_grant2", {6'd0, g_who[2]}, 8'd1);
        chk8("rr_grant3", {6'd0, g_who[3]}, 8'd2);
        chk8("rr_addr0", g_addr[0], 8'h00);
        chk8("rr_addr1", g_addr[1], 8'h20);
        chk1("rr_no_ovf", spi_ovf, 1'b0);

        // Two 01 commands while the host owns the RAM: second one dropped.
        apply_reset();
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        step();
        chk1("ovf_host_gnt", host_gnt, 1'b1);
        host_req = 1'b0;
        rx_data = {2'b01, 8'h81}; rx_valid = 1'b1;
        step();
        chk1("ovf_first_ok", spi_ovf, 1'b0);
        rx_data = {2'b01, 8'h82};
        step();
        rx_valid = 1'b0;
        chk1("ovf_set", spi_ovf, 1'b1);
        chk1("ovf_host_rvalid", host_rvalid, 1'b1);
        chk8("ovf_host_rdata", host_rdata, 8'h3C);
        step();
        chk1("ovf_wr_en", mem_en, 1'b1);
        chk1("ovf_wr_we", mem_we, 1'b1);
        chk8("ovf_wr_data", mem_wdata, 8'h81);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (mem_en) cnt++;
        end
        chk8("ovf_no_second", 8'(cnt), 8'd0);
        chk1("ovf_sticky", spi_ovf, 1'b1);
        apply_reset();
        chk1("ovf_cleared", spi_ovf, 1'b0);

        // Reset during SPI_RSP with a pending write queued behind it.
        send_rx({2'b00, 8'h00});
        send_rx({2'b01, 8'h5A});
        step(); step();
        send_rx({2'b10, 8'h07});
        send_rx({2'b11, 8'h00});
        step();
        rx_data = {2'b01, 8'hEE}; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk1("rsp_rst_tx_valid", tx_valid, 1'b0);
        chk8("rsp_rst_tx_data", tx_data, 8'h00);
        chk1("rsp_rst_mem_en", mem_en, 1'b0);
        chk8("rsp_rst_mem_addr", mem_addr, 8'h00);
        chk8("rsp_rst_mem_wdata", mem_wdata, 8'h00);
        chk8("rsp_rst_host_rdata", host_rdata, 8'h00);
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (mem_en || tx_valid) cnt++;
        end
        chk8("rsp_rst_quiet", 8'(cnt), 8'd0);
        send_rx({2'b11, 8'h00});
        step();
        chk1("rsp_rd0_en", mem_en, 1'b1);
        chk8("rsp_rd0_addr", mem_addr, 8'h00);
        step(); step();
        chk1("rsp_rd0_tx_valid", tx_valid, 1'b1);
        chk8("rsp_rd0_tx_data", tx_data, 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
